// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
//   8N1 UART receiver, LSB first. The asynchronous RX pin is brought into the
//   clock domain through a two-flop synchroniser. The start bit is confirmed
//   at its centre, then each data bit and the stop bit are sampled at their
//   centres. A good byte is held in a one-entry buffer until the MMIO read
//   path acknowledges it.
//
// Ports
//   i_clk        system clock, all logic on the rising edge
//   i_rst        synchronous active-high reset
//   i_uart_rx    asynchronous serial input, idle high
//   i_ack        read acknowledge, clears o_valid / o_frame_err / o_overrun
//   o_data       last good received byte, meaningful while o_valid = 1
//   o_valid      a byte is waiting to be read
//   o_frame_err  sticky: a stop bit was sampled low
//   o_overrun    sticky: a byte completed while the buffer was still full
//   o_busy       receiver is in the middle of a frame
// ---------------------------------------------------------------------------
module uart_rx #(
    parameter int CLOCK_HZ  = 50_000_000,
    parameter int BAUD_RATE = 115_200
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_uart_rx,
    input  logic       i_ack,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_frame_err,
    output logic       o_overrun,
    output logic       o_busy
);

    localparam int CLK_PER_BIT = CLOCK_HZ / BAUD_RATE;
    localparam int HALF        = CLK_PER_BIT / 2;
    localparam int CNT_W       = $clog2(CLK_PER_BIT);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLK_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    logic             sync1_q, sync1_d;
    logic             rx_s_q, rx_s_d;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;

    // Next-state logic. The ack clears are applied first so that events
    // completing in the same cycle (a new byte, a bad stop) override them.
    always_comb begin
        sync1_d     = i_uart_rx;
        rx_s_d      = sync1_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = valid_q;
        frame_err_d = frame_err_q;
        overrun_d   = overrun_q;

        if (i_ack) begin
            valid_d     = 1'b0;
            frame_err_d = 1'b0;
            overrun_d   = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (!rx_s_q) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                end
            end

            ST_START: begin
                if (cnt_q == HALF_LAST) begin
                    // A start bit that is already high again at mid-bit was
                    // a glitch; drop it silently.
                    if (rx_s_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d   = ST_DATA;
                        cnt_d     = '0;
                        bit_idx_d = 3'd0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            ST_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    shift_d[bit_idx_q] = rx_s_q;
                    cnt_d              = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            ST_STOP: begin
                // Leave at the stop-bit centre so a back-to-back start edge
                // is never missed.
                if (cnt_q == BIT_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    if (rx_s_q) begin
                        // An ack in this same cycle frees the buffer for the
                        // new byte instead of counting as an overrun.
                        if (valid_q && !i_ack) begin
                            overrun_d = 1'b1;
                        end else begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers; the synchroniser resets to the idle line level.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync1_q     <= 1'b1;
            rx_s_q      <= 1'b1;
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'h00;
            data_q      <= 8'h00;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            rx_s_q      <= rx_s_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign o_data      = data_q;
    assign o_valid     = valid_q;
    assign o_frame_err = frame_err_q;
    assign o_overrun   = overrun_q;
    assign o_busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
//   Directed bench for uart_rx at 16 clocks per bit. A table of frames with
//   hand-computed buffer/flag results is replayed in a loop; latency, glitch,
//   same-cycle ack and mid-frame reset are exercised by explicit sequences.
// ---------------------------------------------------------------------------
module tb_uart_rx;

    localparam int CPB = 16;

    logic       i_clk;
    logic       i_rst;
    logic       i_uart_rx;
    logic       i_ack;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_frame_err;
    logic       o_overrun;
    logic       o_busy;

    int tests_run;
    int tests_failed;

    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        logic       ack_first;
        logic [7:0] exp_data;
        logic       exp_valid;
        logic       exp_fe;
        logic       exp_ovr;
    } vec_t;

    vec_t vecs[8];

    uart_rx #(
        .CLOCK_HZ (1_600_000),
        .BAUD_RATE(100_000)
    ) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_uart_rx  (i_uart_rx),
        .i_ack      (i_ack),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .o_frame_err(o_frame_err),
        .o_overrun  (o_overrun),
        .o_busy     (o_busy)
    );

    // 10 ns system clock
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Compare one observed value against its expected value
    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Hold the line at one level for a full bit period
    task automatic drive_bit(input logic b);
        i_uart_rx = b;
        repeat (CPB) @(posedge i_clk);
        #1;
    endtask

    // Transmit one 8N1 frame, LSB first, with a chosen stop-bit level
    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        @(posedge i_clk);
        #1;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop_bit);
        i_uart_rx = 1'b1;
    endtask

    // One-cycle acknowledge pulse
    task automatic pulse_ack();
        @(posedge i_clk);
        #1 i_ack = 1'b1;
        @(posedge i_clk);
        #1 i_ack = 1'b0;
    endtask

    // Ack held high across the edge on which a frame started together with
    // this task completes its stop bit (edge 155 after the start edge)
    task automatic ack_at_completion();
        @(posedge i_clk);
        repeat (154) @(posedge i_clk);
        #1 i_ack = 1'b1;
        @(posedge i_clk);
        #1 i_ack = 1'b0;
    endtask

    // Replay one table row and compare the buffer and flags afterwards
    task automatic apply_stimulus(input vec_t v, input int idx);
        if (v.ack_first) pulse_ack();
        send_frame(v.data, v.stop_bit);
        @(negedge i_clk);
        check_output($sformatf("vec%0d data", idx), {24'd0, o_data}, {24'd0, v.exp_data});
        check_output($sformatf("vec%0d valid", idx), {31'd0, o_valid}, {31'd0, v.exp_valid});
        check_output($sformatf("vec%0d frame_err", idx), {31'd0, o_frame_err}, {31'd0, v.exp_fe});
        check_output($sformatf("vec%0d overrun", idx), {31'd0, o_overrun}, {31'd0, v.exp_ovr});
    endtask

    // Main sequence
    initial begin
        int  lat;
        bit  found;

        tests_run    = 0;
        tests_failed = 0;
        i_rst        = 1'b1;
        i_uart_rx    = 1'b1;
        i_ack        = 1'b0;

        // data, stop, ack_first, exp_data, exp_valid, exp_fe, exp_ovr
        vecs[0] = '{8'h3C, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{8'h11, 1'b1, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{8'h22, 1'b1, 1'b0, 8'h11, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{8'h55, 1'b1, 1'b1, 8'h55, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{8'hF0, 1'b1, 1'b1, 8'hF0, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{8'h81, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b1, 1'b0};

        repeat (3) @(posedge i_clk);
        #1 i_rst = 1'b0;
        @(negedge i_clk);
        check_output("reset data", {24'd0, o_data}, 32'h0);
        check_output("reset valid", {31'd0, o_valid}, 32'h0);
        check_output("reset frame_err", {31'd0, o_frame_err}, 32'h0);
        check_output("reset overrun", {31'd0, o_overrun}, 32'h0);
        check_output("reset busy", {31'd0, o_busy}, 32'h0);

        // Good frame 0xA5 with latency measured from the start edge
        lat   = 0;
        found = 1'b0;
        fork
            send_frame(8'hA5, 1'b1);
            begin
                for (int i = 0; i < 200 && !found; i++) begin
                    @(negedge i_clk);
                    if (o_valid) found = 1'b1;
                    else lat++;
                end
            end
        join
        check_output("A5 valid seen", {31'd0, found}, 32'h1);
        check_output("A5 latency in 152..156", {31'd0, (lat >= 152 && lat <= 156)}, 32'h1);
        @(negedge i_clk);
        check_output("A5 data", {24'd0, o_data}, 32'hA5);
        check_output("A5 frame_err", {31'd0, o_frame_err}, 32'h0);
        check_output("A5 overrun", {31'd0, o_overrun}, 32'h0);
        check_output("A5 busy after frame", {31'd0, o_busy}, 32'h0);
        pulse_ack();
        @(negedge i_clk);
        check_output("A5 valid after ack", {31'd0, o_valid}, 32'h0);

        // Five-cycle low glitch on an idle line
        @(posedge i_clk);
        #1 i_uart_rx = 1'b0;
        repeat (5) @(posedge i_clk);
        #1 i_uart_rx = 1'b1;
        @(negedge i_clk);
        check_output("glitch busy during", {31'd0, o_busy}, 32'h1);
        repeat (12) @(posedge i_clk);
        @(negedge i_clk);
        check_output("glitch busy after", {31'd0, o_busy}, 32'h0);
        check_output("glitch valid", {31'd0, o_valid}, 32'h0);
        check_output("glitch frame_err", {31'd0, o_frame_err}, 32'h0);

        // Table of frames: bad stop, overrun, assorted good bytes
        for (int i = 0; i < 8; i++) apply_stimulus(vecs[i], i);

        // Ack clears valid and both sticky flags
        pulse_ack();
        @(negedge i_clk);
        check_output("ack clears valid", {31'd0, o_valid}, 32'h0);
        check_output("ack clears frame_err", {31'd0, o_frame_err}, 32'h0);
        check_output("ack clears overrun", {31'd0, o_overrun}, 32'h0);

        // 0x55 then 0xF0, with the ack landing in 0xF0's completion cycle
        send_frame(8'h55, 1'b1);
        @(negedge i_clk);
        check_output("55 data", {24'd0, o_data}, 32'h55);
        check_output("55 valid", {31'd0, o_valid}, 32'h1);
        fork
            send_frame(8'hF0, 1'b1);
            ack_at_completion();
        join
        @(negedge i_clk);
        check_output("F0 same-cycle ack data", {24'd0, o_data}, 32'hF0);
        check_output("F0 same-cycle ack valid", {31'd0, o_valid}, 32'h1);
        check_output("F0 same-cycle ack overrun", {31'd0, o_overrun}, 32'h0);

        // Ack in the same cycle as a bad stop: the error flag still sets
        fork
            send_frame(8'h3C, 1'b0);
            ack_at_completion();
        join
        @(negedge i_clk);
        check_output("bad stop + ack frame_err", {31'd0, o_frame_err}, 32'h1);
        check_output("bad stop + ack valid", {31'd0, o_valid}, 32'h0);
        check_output("bad stop + ack data", {24'd0, o_data}, 32'hF0);

        // Reset at the centre of bit 4 of 0x81 abandons the frame
        @(posedge i_clk);
        #1;
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b0);
        i_uart_rx = 1'b0;
        repeat (CPB / 2) @(posedge i_clk);
        @(negedge i_clk);
        check_output("pre-reset busy", {31'd0, o_busy}, 32'h1);
        @(posedge i_clk);
        #1 i_rst = 1'b1;
        @(posedge i_clk);
        #1 i_rst = 1'b0;
        i_uart_rx = 1'b1;
        @(negedge i_clk);
        check_output("mid-frame reset data", {24'd0, o_data}, 32'h0);
        check_output("mid-frame reset valid", {31'd0, o_valid}, 32'h0);
        check_output("mid-frame reset frame_err", {31'd0, o_frame_err}, 32'h0);
        check_output("mid-frame reset overrun", {31'd0, o_overrun}, 32'h0);
        check_output("mid-frame reset busy", {31'd0, o_busy}, 32'h0);
        repeat (20) @(posedge i_clk);
        send_frame(8'h7E, 1'b1);
        @(negedge i_clk);
        check_output("7E data", {24'd0, o_data}, 32'h7E);
        check_output("7E valid", {31'd0, o_valid}, 32'h1);
        check_output("7E frame_err", {31'd0, o_frame_err}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
